// File: rtl/spi_master_seq_if.sv
// Command/response handshake bundle between a client and spi_master_seq.
// The client drives the master modport, the sequencer uses the slave modport.
interface spi_master_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [7:0]  cmd_nbits;
  logic        cmd_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_nbits, cmd_rd, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_nbits, cmd_rd, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_master_seq.sv
// Command FIFO plus sequencer that issues transactions to an spi_master port.
// Define SPI_SEQ_TIMEOUT_EN to add the ack watchdog and sticky err flag.
//
// state | meaning
// IDLE  | waiting for a queued command with ack low
// REQ   | wr_req/rd_req asserted, waiting for ack (or watchdog expiry)
// RSP   | response word presented, waiting for rsp_ready
// GAP   | enforcing minimum idle time and ack release before next command
module spi_master_seq #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_master_seq_if.slave        cmd_if,
  output logic                   wr_req,
  output logic                   rd_req,
  output logic [31:0]            wr_data,
  output logic [7:0]             nb_mosi,
  output logic [7:0]             nb_miso,
  output logic [31:0]            nb_sclk,
  input  logic                   ack,
  input  logic [31:0]            rd_data,
  output logic                   busy,
  output logic                   err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef struct packed {
    logic        rd;
    logic [7:0]  nbits;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_GAP} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          cmd_ready_q;
  logic          push;
  logic          pop;

  state_t        state;
  logic          cur_rd;
  logic [GW-1:0] gap_cnt;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          req_done;
  logic [31:0]   done_word;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;
`endif

  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;

  assign head = mem[rd_ptr];
  assign push = cmd_if.cmd_valid && cmd_ready_q;
  // No bypass: a command must land in the FIFO before IDLE can pop it.
  assign pop  = (state == S_IDLE) && (count != '0) && !ack;
  assign busy = (state != S_IDLE) || (count != '0);

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: cmd_if.cmd_rd, nbits: cmd_if.cmd_nbits, data: cmd_if.cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      cmd_ready_q <= (count_nxt != CW'(DEPTH));
    end
  end

  always_comb begin
    req_done  = ack;
    done_word = rd_data;
`ifdef SPI_SEQ_TIMEOUT_EN
    if (!ack && (to_cnt == '0)) begin
      req_done  = 1'b1;
      done_word = 32'hDEAD_BEEF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      wr_data     <= '0;
      nb_mosi     <= '0;
      nb_miso     <= '0;
      nb_sclk     <= '0;
      cur_rd      <= 1'b0;
      gap_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // Zero-length entries are popped and dropped without a transaction.
          if (pop && (head.nbits != 8'd0)) begin
            state   <= S_REQ;
            wr_req  <= 1'b1;
            rd_req  <= head.rd;
            cur_rd  <= head.rd;
            wr_data <= head.data;
            nb_mosi <= head.nbits;
            nb_miso <= head.nbits;
            nb_sclk <= {24'd0, head.nbits};
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt  <= TW'(TIMEOUT - 1);
`endif
          end
        end
        S_REQ: begin
          if (req_done) begin
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            if (cur_rd) begin
              rsp_data_q  <= done_word;
              rsp_valid_q <= 1'b1;
              state       <= S_RSP;
            end else begin
              gap_cnt <= GW'(GAP);
              state   <= S_GAP;
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            if (!ack) err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt - TW'(1);
`endif
          end
        end
        S_RSP: begin
          if (cmd_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gap_cnt     <= GW'(GAP);
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (!ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_seq.sv
// Randomized bench for spi_master_seq: a loopback spi_master model plus a queue
// scoreboard of expected transactions and responses.
module tb_spi_master_seq;
  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic        rd;
    logic [7:0]  nb;
    logic [31:0] d;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req, rd_req, busy, err;
  logic [31:0] wr_data, nb_sclk;
  logic [7:0]  nb_mosi, nb_miso;
  logic        ack;
  logic [31:0] rd_data;

  cmd_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_txn = 0;
  int          n_rsp = 0;
  logic        stall = 1'b1;
  logic        rsp_en = 1'b0;

  always #5 clk = ~clk;

  spi_master_seq_if cmd_if ();

  spi_master_seq #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_if  (cmd_if),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .wr_data (wr_data),
    .nb_mosi (nb_mosi),
    .nb_miso (nb_miso),
    .nb_sclk (nb_sclk),
    .ack     (ack),
    .rd_data (rd_data),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input logic [7:0] nb);
    logic [63:0] m;
    m = (64'd1 << nb) - 64'd1;
    return m[31:0];
  endfunction

  // Loopback spi_master: acks after a random delay, returns mosi as miso.
  initial begin : spi_dev
    int   wait_cnt;
    int   low_cnt;
    logic prev_req;
    logic seen_txn;
    cmd_t e;
    wait_cnt = 0; low_cnt = 0; prev_req = 1'b0; seen_txn = 1'b0;
    ack = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0; prev_req = 1'b0; seen_txn = 1'b0; low_cnt = 0; wait_cnt = 0;
      end else begin
        if (wr_req && !prev_req) begin
          if (seen_txn) chk("gap_cycles", 32'(low_cnt >= GAP), 32'd1);
          n_txn++;
        end
        if (wr_req) low_cnt = 0;
        else        low_cnt++;
        if (!wr_req && prev_req) seen_txn = 1'b1;
        prev_req = wr_req;
        if (ack) begin
          if (!wr_req) begin
            ack = 1'b0;
            wait_cnt = $urandom_range(0, 3);
          end
        end else if (wr_req && !stall) begin
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            if (exp_q.size() == 0) begin
              chk("txn_expected_q", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              chk("txn_wr_data", wr_data, e.d);
              chk("txn_nb_mosi", {24'd0, nb_mosi}, {24'd0, e.nb});
              chk("txn_nb_miso", {24'd0, nb_miso}, {24'd0, e.nb});
              chk("txn_nb_sclk", nb_sclk, {24'd0, e.nb});
              chk("txn_rd_req", {31'd0, rd_req}, {31'd0, e.rd});
              if (e.rd) rsp_q.push_back(e.d & mask(e.nb));
            end
            rd_data = wr_data & mask(nb_miso);
            ack = 1'b1;
          end
        end
      end
    end
  end

  initial begin : rsp_sink
    cmd_if.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      cmd_if.rsp_ready = rsp_en && ($urandom_range(0, 3) != 0);
      if (rst_n && cmd_if.rsp_ready && cmd_if.rsp_valid) begin
        n_rsp++;
        if (rsp_q.size() == 0) chk("rsp_expected_q", 32'(rsp_q.size()), 32'd1);
        else                   chk("rsp_data", cmd_if.rsp_data, rsp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic rd, input logic [7:0] nb, input logic [31:0] d);
    int guard;
    cmd_t c;
    guard = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rd    = rd;
    cmd_if.cmd_nbits = nb;
    cmd_if.cmd_data  = d;
    while (!cmd_if.cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk("push_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    c.rd = rd; c.nb = nb; c.d = d;
    if (nb != 8'd0) exp_q.push_back(c);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy || ack || exp_q.size() != 0 || rsp_q.size() != 0) && guard < 5000);
    chk("drain_idle", {29'd0, busy, exp_q.size() != 0, rsp_q.size() != 0}, 32'd0);
  endtask

  task automatic wait_wr_req();
    int guard;
    guard = 0;
    while (!wr_req && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wr_req_seen", {31'd0, wr_req}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int t0;
    int r0;
    int n_issue;
    int hi;
    logic       rd;
    logic [7:0] nb;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_nbits = '0;
    cmd_if.cmd_rd    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_nb_sclk", nb_sclk, 32'd0);
    chk("rst_rsp_data", cmd_if.rsp_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Push-to-wr_req latency with a read that the loopback returns.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rd    = 1'b1;
    cmd_if.cmd_nbits = 8'd16;
    cmd_if.cmd_data  = 32'h0000_5aaa;
    exp_q.push_back('{rd: 1'b1, nb: 8'd16, d: 32'h0000_5aaa});
    r0 = n_rsp;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    chk("lat_edge1_wr_req", {31'd0, wr_req}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_wr_req", {31'd0, wr_req}, 32'd1);
    chk("lat_edge2_rd_req", {31'd0, rd_req}, 32'd1);
    chk("lat_wr_data", wr_data, 32'h0000_5aaa);
    chk("lat_nb_sclk", nb_sclk, 32'd16);
    stall = 1'b0;
    rsp_en = 1'b1;
    wait_idle();
    chk("loopback_rsp_count", 32'(n_rsp - r0), 32'd1);

    // Read then write back-to-back: two transactions, one response.
    t0 = n_txn; r0 = n_rsp;
    push(1'b1, 8'd17, 32'h0001_5aaa);
    push(1'b0, 8'd8, 32'h0000_00a5);
    wait_idle();
    chk("b2b_txn_count", 32'(n_txn - t0), 32'd2);
    chk("b2b_rsp_count", 32'(n_rsp - r0), 32'd1);

    // Master stalled: one issued, FIFO fills, then all drain in order.
    stall = 1'b1;
    t0 = n_txn;
    for (int i = 0; i < 5; i++) push(1'($urandom_range(0, 1)), 8'($urandom_range(1, 32)), $urandom);
    repeat (2) @(negedge clk);
    chk("full_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("stall_txn_count", 32'(n_txn - t0), 32'd1);
    stall = 1'b0;
    wait_idle();
    chk("stall_drain_count", 32'(n_txn - t0), 32'd5);
    chk("drained_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Response back-pressure blocks the next transaction.
    rsp_en = 1'b0;
    t0 = n_txn;
    push(1'b1, 8'd24, 32'h00c0_ffee);
    push(1'b1, 8'd5, 32'h0000_0013);
    repeat (50) @(negedge clk);
    chk("bp_txn_count", 32'(n_txn - t0), 32'd1);
    chk("bp_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd1);
    rsp_en = 1'b1;
    wait_idle();
    chk("bp_drain_count", 32'(n_txn - t0), 32'd2);

    // Random mix including zero-length commands.
    t0 = n_txn;
    n_issue = 0;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 32));
      if (nb != 8'd0) n_issue++;
      push(rd, nb, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    wait_idle();
    chk("rand_txn_count", 32'(n_txn - t0), 32'(n_issue));

    // Reset in the middle of a transaction.
    stall = 1'b1;
    push(1'b1, 8'd12, 32'h0000_0abc);
    push(1'b0, 8'd3, 32'h0000_0005);
    wait_wr_req();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("arst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd0);
    exp_q.delete();
    rsp_q.delete();
    r0 = n_rsp; t0 = n_txn;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_no_rsp", 32'(n_rsp - r0), 32'd0);
    chk("arst_no_txn", 32'(n_txn - t0), 32'd0);
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: ack never arrives.
    stall = 1'b1;
    rsp_en = 1'b0;
    push(1'b1, 8'd8, 32'h0000_0033);
    wait_wr_req();
    hi = 0;
    while (wr_req && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(hi), 32'(TIMEOUT));
    @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd1);
    chk("to_rsp_data", cmd_if.rsp_data, 32'hDEAD_BEEF);
    exp_q.delete();
    rsp_q.push_back(32'hDEAD_BEEF);
    rsp_en = 1'b1;
    wait_idle();
    stall = 1'b0;
    push(1'b0, 8'd4, 32'h0000_0009);
    wait_idle();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
`else
    hi = 0;
    chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

    chk("final_queues", 32'(exp_q.size() + rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
